rank_select: RTL
================

Name: rank_select

Overview:
- Consumer end of the masked rank interface in the Masked2DFilter kernel.
- Holds the N-sample sliding window aligned with the rank generator's slots (slot N-1 newest, slot 0 oldest).
- Takes the per-slot rank vector and picks the sample whose rank equals the target order statistic k: min, median, max or a programmed k.
- Output is a 2-stage pipeline with valid/ready back-pressure toward the pixel sink.

Parameters:
- N, 7, window length; must match the rank generator.
- DATA_W, 8, sample width.
- RANK_BITS, $clog2(N+1), width of each rank field; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  new sample offered.
- in_ready  out  1  sample accepted when in_valid && in_ready. The same strobe clock-enables the rank generator.
- in_data  in  DATA_W  new sample.
- ranks_in  in  RANK_BITS*N  slot j rank at bits [j*RANK_BITS +: RANK_BITS]. Masked slots hold 1..M; unmasked slots hold 0.
- mask  in  N  active slots; same vector the rank generator uses.
- sel_mode  in  2  0 = min, 1 = median, 2 = max, 3 = custom.
- k_cfg  in  RANK_BITS  custom target rank.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  selected sample.
- out_none  out  1  no slot matched k.
- out_slot  out  $clog2(N)  index of the selected slot.

Behaviour:
- Reset (async, rst=0):
  - window regs = 0, fill_cnt = 0.
  - s1_v = 0, out_valid = 0, out_data = 0, out_none = 0, out_slot = 0.
- Pipeline control:
  - adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - When adv=0, all state holds: window, fill_cnt, stage 1, output.
- Accept edge (in_valid && in_ready):
  - win[N-1] <= in_data; win[i] <= win[i+1] for i < N-1.
  - fill_cnt increments, saturating at N.
  - Rank generator advances on the same edge. ranks_in is therefore valid for the new window during the next cycle.
- Stage 1 (edge after accept, when adv=1):
  - M = popcount(mask).
  - k by sel_mode:
    - min: k = 1.
    - median: k = (M+1)>>1.
    - max: k = M.
    - custom: k = clamp(k_cfg, 1, M).
  - match[j] = mask[j] && (ranks_in[j] == k) && (M != 0).
  - Register match, a copy of win, and s1_v.
  - s1_v = 1 only if the preceding cycle had an accept and fill_cnt == N after that accept. The first N-1 accepts after reset produce no output.
- Stage 2 (when adv=1):
  - out_valid <= s1_v.
  - If match has a set bit: out_data = win copy at the lowest set index; out_slot = that index; out_none = 0.
  - If match == 0 (M == 0 or k not present): out_data = 0, out_slot = 0, out_none = 1.
  - A multi-hot match (rank ties upstream) resolves to the lowest index; this is not an error.
- Latency: out_valid rises 2 edges after the accept edge.
- Throughput: one result per clock while out_ready=1.
- Stall: out_valid && !out_ready holds out_* stable, drops in_ready and freezes stage 1. A held result must not change.
- Mask and sel_mode are sampled in stage 1. They must be stable from the accept edge through the stage 1 edge.
- Reset mid-stream: pending results are discarded and the window refills from fill_cnt = 0.

Test Plan:
- Fill: N=7, mask=7'h7F, median, feed 10,20,...,70 with ranks_in driven consistent with the window. Required: no out_valid before the 7th accept; then out_data=40, out_slot=3, out_valid exactly 2 edges after the 7th accept.
- Modes: same window, sel_mode=0 -> out_data=10; sel_mode=2 -> out_data=70; sel_mode=3 with k_cfg=6 -> out_data=60; k_cfg=0 -> out_data=10 (clamped); k_cfg=7 with mask=7'h0F -> max of slots 0..3.
- Sparse mask: mask=7'b1010101 (M=4), median k=2. Drive slot 0 rank 3, slot 2 rank 1, slot 4 rank 2, slot 6 rank 4 -> out_slot=4, out_data=win[4].
- Empty mask: mask=0, all ranks 0 -> out_valid=1, out_none=1, out_data=0.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1. Required: in_ready=0, out_data unchanged, window unchanged. Release: results resume in order, no loss or duplication.
- Async reset asserted mid-stream with a result pending: out_valid drops immediately. After release, 6 accepts give no output and the 7th gives output 2 edges later.

Source files
------------

// File: rtl/rank_select.sv
// Order-statistic selector for the masked 2D filter: keeps the sample window,
// picks the slot whose rank equals the requested k, and drives a 2-stage output pipeline.
module rank_select #(
  parameter  int unsigned N         = 7,
  parameter  int unsigned DATA_W    = 8,
  localparam int unsigned RANK_BITS = $clog2(N + 1),
  localparam int unsigned SLOT_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [RANK_BITS*N-1:0] ranks_in,
  input  logic [N-1:0]           mask,
  input  logic [1:0]             sel_mode,
  input  logic [RANK_BITS-1:0]   k_cfg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_none,
  output logic [SLOT_W-1:0]      out_slot
);

  localparam int unsigned CNT_W = RANK_BITS;

  localparam logic [1:0] MODE_MIN    = 2'd0;
  localparam logic [1:0] MODE_MEDIAN = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_CUSTOM = 2'd3;

  logic                 adv;
  logic                 accept;
  logic [DATA_W-1:0]    win [N];
  logic [CNT_W-1:0]     fill_cnt;
  logic                 acc_q;

  logic [RANK_BITS-1:0] m_cnt;
  logic [RANK_BITS:0]   m_plus1;
  logic [RANK_BITS-1:0] k_sel;
  logic [N-1:0]         match;

  logic                 s1_v;
  logic [N-1:0]         s1_match;
  logic [DATA_W-1:0]    s1_win [N];

  logic                 sel_found;
  logic [SLOT_W-1:0]    sel_idx;
  logic [DATA_W-1:0]    sel_data;

  // The whole pipeline moves together; a stalled output freezes everything upstream.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Sliding window: newest sample enters at slot N-1, oldest leaves from slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < N - 1; i++) win[i] <= win[i + 1];
      win[N-1] <= in_data;
      if (fill_cnt != CNT_W'(N)) fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  // Marks that ranks_in now describes a freshly shifted window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 1'b0;
    end else if (adv) begin
      acc_q <= accept;
    end
  end

  // Active-slot count and the target rank for the selected mode.
  always_comb begin
    m_cnt = '0;
    for (int j = 0; j < N; j++) m_cnt = m_cnt + RANK_BITS'(mask[j]);
    m_plus1 = {1'b0, m_cnt} + (RANK_BITS + 1)'(1);
    k_sel   = '0;
    case (sel_mode)
      MODE_MIN:    k_sel = RANK_BITS'(1);
      MODE_MEDIAN: k_sel = m_plus1[RANK_BITS:1];
      MODE_MAX:    k_sel = m_cnt;
      MODE_CUSTOM: begin
        if (k_cfg == '0)        k_sel = RANK_BITS'(1);
        else if (k_cfg > m_cnt) k_sel = m_cnt;
        else                    k_sel = k_cfg;
      end
      default:     k_sel = '0;
    endcase
  end

  always_comb begin
    match = '0;
    for (int j = 0; j < N; j++) begin
      match[j] = mask[j] && (ranks_in[j*RANK_BITS +: RANK_BITS] == k_sel) && (m_cnt != '0);
    end
  end

  // Stage 1: capture the match vector alongside the window it refers to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_match <= '0;
      for (int i = 0; i < N; i++) s1_win[i] <= '0;
    end else if (adv) begin
      s1_v     <= acc_q && (fill_cnt == CNT_W'(N));
      s1_match <= match;
      for (int i = 0; i < N; i++) s1_win[i] <= win[i];
    end
  end

  // Lowest set match bit wins, so rank ties upstream resolve deterministically.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (s1_match[j]) begin
        sel_found = 1'b1;
        sel_idx   = SLOT_W'(j);
        sel_data  = s1_win[j];
      end
    end
  end

  // Stage 2: registered result toward the pixel sink.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_none  <= 1'b0;
      out_slot  <= '0;
    end else if (adv) begin
      out_valid <= s1_v;
      out_data  <= sel_data;
      out_none  <= !sel_found;
      out_slot  <= sel_idx;
    end
  end

endmodule
